// File: rtl/iob_ram_be_ctrl_pkg.sv
// Shared definitions for the iob_ram_be_ctrl request front-end.
// Holds the front-end state encodings and the credit counter width helper.
package iob_ram_be_ctrl_pkg;

    // Front-end states: memory clear sweep, then normal request service.
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // Credit counter width: it must count up to 2 reads in flight plus a full FIFO.
    function automatic int crd_width(input int depth);
        return $clog2(depth + 3);
    endfunction

endpackage

// File: rtl/iob_ram_be_ctrl_rsp_fifo.sv
// Response FIFO for iob_ram_be_ctrl.
// Synchronous, DEPTH x DATA_W. The head entry is presented directly and a level
// count is exported so the front-end can compute request credit.
// Storage is cleared on reset so the head reads as zero while the FIFO is empty.
module iob_ram_be_ctrl_rsp_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic              push_s;
    logic              pop_s;

    // Pointer increment that wraps at DEPTH, so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // Never pop an empty FIFO; a push into a full FIFO is only allowed alongside a pop.
    always_comb begin
        pop_s  = pop && (level_r != {LVL_W{1'b0}});
        push_s = push && ((level_r != LVL_W'(DEPTH)) || pop_s);
    end

    // Storage, pointers and occupancy level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign level = level_r;

endmodule

// File: rtl/iob_ram_be_ctrl.sv
// iob_ram_be_ctrl: request front-end for one port of a byte-enable dual-port RAM.
// Turns a valid/ready request stream into registered RAM port controls and
// returns read data, in order, through a credit-protected response FIFO.
// Optional build macro IOB_RAM_BE_CTRL_CLEAR_EN: after reset, sweep every address
// writing CLEAR_VAL (busy_o=1) before accepting requests.
module iob_ram_be_ctrl
    import iob_ram_be_ctrl_pkg::*;
#(
    parameter int                 DATA_W    = 32,
    parameter int                 ADDR_W    = 4,
    parameter int                 RSP_DEPTH = 4,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    input  logic [DATA_W/8-1:0]   req_wstrb_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic                  busy_o,
    output logic                  ram_en_o,
    output logic [DATA_W/8-1:0]   ram_we_o,
    output logic [ADDR_W-1:0]     ram_addr_o,
    output logic [DATA_W-1:0]     ram_d_o,
    input  logic [DATA_W-1:0]     ram_d_i
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CRD_W  = crd_width(RSP_DEPTH);
    localparam int LVL_W  = $clog2(RSP_DEPTH + 1);

    logic [0:0]        state_s;
    logic [ADDR_W-1:0] sweep_addr_s;
    logic              clear_s;
    logic              accept_s;
    logic              rd_req_s;
    logic              pop_s;
    logic              rd_p0_r;     // read presented to the RAM this cycle
    logic              rd_p1_r;     // RAM read data valid on ram_d_i this cycle
    logic [LVL_W-1:0]  level_s;
    logic [CRD_W-1:0]  credit_s;

`ifdef IOB_RAM_BE_CTRL_CLEAR_EN
    logic [0:0]        state_r;
    logic [ADDR_W-1:0] cnt_r;

    // Clear sweep: one address per cycle, leave for RUN after the last address.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_r <= ST_CLEAR;
            cnt_r   <= {ADDR_W{1'b0}};
        end else if (state_r == ST_CLEAR) begin
            if (cnt_r == {ADDR_W{1'b1}}) begin
                state_r <= ST_RUN;
                cnt_r   <= {ADDR_W{1'b0}};
            end else begin
                state_r <= ST_CLEAR;
                cnt_r   <= cnt_r + ADDR_W'(1);
            end
        end else begin
            state_r <= ST_RUN;
            cnt_r   <= cnt_r;
        end
    end

    assign state_s      = state_r;
    assign sweep_addr_s = cnt_r;
`else
    assign state_s      = ST_RUN;
    assign sweep_addr_s = {ADDR_W{1'b0}};
`endif

    // Credit: reads already issued but not yet in the FIFO reserve an entry too,
    // so the FIFO can never overflow regardless of rsp_ready_i.
    always_comb begin
        clear_s     = (state_s == ST_CLEAR);
        credit_s    = CRD_W'(rd_p0_r) + CRD_W'(rd_p1_r) + CRD_W'(level_s);
        req_ready_o = !clear_s && (credit_s < CRD_W'(RSP_DEPTH));
        accept_s    = req_valid_i && req_ready_o;
        rd_req_s    = accept_s && (req_wstrb_i == {STRB_W{1'b0}});
        rsp_valid_o = (level_s != {LVL_W{1'b0}});
        pop_s       = rsp_valid_o && rsp_ready_i;
        busy_o      = clear_s;
    end

    // RAM port registers: sweep write, accepted request, or idle (addr/data hold).
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ram_en_o   <= 1'b0;
            ram_we_o   <= {STRB_W{1'b0}};
            ram_addr_o <= {ADDR_W{1'b0}};
            ram_d_o    <= {DATA_W{1'b0}};
        end else if (clear_s) begin
            ram_en_o   <= 1'b1;
            ram_we_o   <= {STRB_W{1'b1}};
            ram_addr_o <= sweep_addr_s;
            ram_d_o    <= CLEAR_VAL;
        end else if (accept_s) begin
            ram_en_o   <= 1'b1;
            ram_we_o   <= req_wstrb_i;
            ram_addr_o <= req_addr_i;
            ram_d_o    <= req_wdata_i;
        end else begin
            ram_en_o   <= 1'b0;
            ram_we_o   <= {STRB_W{1'b0}};
        end
    end

    // Two-stage read tracker: RAM enable cycle, then RAM data cycle (push).
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rd_p0_r <= 1'b0;
            rd_p1_r <= 1'b0;
        end else begin
            rd_p0_r <= rd_req_s;
            rd_p1_r <= rd_p0_r;
        end
    end

    iob_ram_be_ctrl_rsp_fifo #(
        .DEPTH  (RSP_DEPTH),
        .DATA_W (DATA_W)
    ) u_rsp_fifo (
        .clk       (clk_i),
        .rst_n     (arst_n_i),
        .push      (rd_p1_r),
        .push_data (ram_d_i),
        .pop       (pop_s),
        .head      (rsp_rdata_o),
        .level     (level_s)
    );

endmodule

// File: tb/tb_iob_ram_be_ctrl.sv
// Bench for iob_ram_be_ctrl with a behavioural byte-enable RAM on its port.
// Reference: word-array memory image plus a queue of expected read data.
module tb_iob_ram_be_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;
    localparam int STRB_W = DATA_W / 8;
    localparam int WORDS  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;
    logic              ram_en;
    logic [STRB_W-1:0] ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_d;
    logic [DATA_W-1:0] ram_dout;

    logic              pre_en;
    logic [ADDR_W-1:0] pre_addr;
    logic [DATA_W-1:0] pre_data;
    logic [DATA_W-1:0] ram_mem [WORDS];

    logic [DATA_W-1:0] model_mem [WORDS];
    logic [DATA_W-1:0] exp_q [$];
    int                n_vec = 0;
    int                n_err = 0;
    int                cyc = 0;
    int                n_fire = 0;
    int                first_fire = -1;
    int                last_fire = -1;
    logic [DATA_W-1:0] last_rdata = 32'd0;
    logic              acc = 1'b0;

    always #5 clk = ~clk;

    iob_ram_be_ctrl #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .RSP_DEPTH (DEPTH),
        .CLEAR_VAL (32'd0)
    ) dut (
        .clk_i       (clk),
        .arst_n_i    (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_wstrb_i (req_wstrb),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .busy_o      (busy),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_d_o     (ram_d),
        .ram_d_i     (ram_dout)
    );

    // Behavioural byte-enable RAM port (registered read), with a bench preload path.
    always @(posedge clk) begin
        if (pre_en) begin
            ram_mem[pre_addr] <= pre_data;
        end else if (ram_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (ram_we[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_d[b*8 +: 8];
            end
            if (ram_we == '0) ram_dout <= ram_mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // One clock: check ready/response against the reference, update it, advance.
    task automatic tick();
        logic fire;
        fire = rsp_valid && rsp_ready;
        if (rst_n) chk("req_ready", 32'(req_ready), 32'(!busy && (exp_q.size() < DEPTH)));
        if (fire) begin
            if (exp_q.size() == 0) begin
                chk("rsp_spurious", 32'(fire), 32'd0);
            end else begin
                chk("rsp_data", rsp_rdata, exp_q.pop_front());
                n_fire++;
                if (first_fire < 0) first_fire = cyc;
                last_fire  = cyc;
                last_rdata = rsp_rdata;
            end
        end
        acc = req_valid && req_ready;
        if (acc) begin
            if (req_wstrb == '0) begin
                exp_q.push_back(model_mem[req_addr]);
            end else begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (req_wstrb[b]) model_mem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic [STRB_W-1:0] s);
        int t;
        t = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        do begin
            tick();
            t++;
        end while (!acc && t < 50);
        chk("issue_accept", 32'(acc), 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        rsp_ready = 1'b1;
        while (exp_q.size() != 0 && t < 50) begin
            tick();
            t++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        tick();
        chk("drain_idle", 32'(rsp_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_d", ram_d, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
`ifdef IOB_RAM_BE_CTRL_CLEAR_EN
        chk("rst_busy", 32'(busy), 32'd1);
        for (int i = 0; i < WORDS; i++) model_mem[i] = 32'd0;
`else
        chk("rst_busy", 32'(busy), 32'd0);
`endif
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_sweep();
`ifdef IOB_RAM_BE_CTRL_CLEAR_EN
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            if (n == 0) begin
                chk("sweep_addr0", 32'(ram_addr), 32'd0);
                chk("sweep_en", 32'(ram_en), 32'd1);
            end
            n++;
        end
        chk("busy_cycles", 32'(n), 32'd16);
`else
        tick();
        chk("busy_off", 32'(busy), 32'd0);
`endif
    endtask

    initial begin
        logic [DATA_W-1:0] w;
        int i;
        int t;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        rsp_ready = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        #1;
        // Fill the RAM with random contents so the clear sweep has something to erase.
        for (int k = 0; k < WORDS; k++) begin
            pre_en = 1'b1; pre_addr = ADDR_W'(k); pre_data = $urandom;
            model_mem[k] = pre_data;
            @(posedge clk);
            #1;
        end
        pre_en = 1'b0;

        do_reset();
`ifdef IOB_RAM_BE_CTRL_CLEAR_EN
        repeat (5) tick();
        chk("mid_sweep_busy", 32'(busy), 32'd1);
        do_reset();
`endif
        wait_sweep();

        // Initial contents: cleared words, or the preloaded image without clear.
        for (int k = 0; k < WORDS; k++) issue(ADDR_W'(k), 32'd0, 4'h0);
        drain();

        // Write 32+i everywhere, then read back with a latency check on the first read.
        for (int k = 0; k < WORDS; k++) issue(ADDR_W'(k), 32'(32 + k), 4'hF);
        issue(4'd0, 32'd0, 4'h0);
        chk("lat_n1", 32'(rsp_valid), 32'd0);
        tick();
        chk("lat_n2", 32'(rsp_valid), 32'd0);
        tick();
        chk("lat_n3", 32'(rsp_valid), 32'd1);
        for (int k = 1; k < WORDS; k++) issue(ADDR_W'(k), 32'd0, 4'h0);
        drain();
        chk("wr_rd_last", last_rdata, 32'd47);

        // Byte strobes merge into the existing word.
        issue(4'd3, 32'hAABBCCDD, 4'hF);
        issue(4'd3, 32'h11223344, 4'b0101);
        issue(4'd3, 32'd0, 4'h0);
        drain();
        chk("byte_merge", last_rdata, 32'hAA22CC44);

        // Backpressure: only DEPTH reads get credit while responses are stalled.
        rsp_ready = 1'b0;
        i = 0;
        t = 0;
        repeat (8) begin
            req_valid = 1'b1; req_addr = ADDR_W'(6 + i); req_wstrb = 4'h0;
            tick();
            if (acc) i++;
        end
        chk("bp_accepted", 32'(i), 32'd4);
        chk("bp_ready", 32'(req_ready), 32'd0);
        n_fire = 0;
        rsp_ready = 1'b1;
        while (i < 6 && t < 50) begin
            req_valid = 1'b1; req_addr = ADDR_W'(6 + i);
            tick();
            if (acc) i++;
            t++;
        end
        req_valid = 1'b0;
        drain();
        chk("bp_delivered", 32'(n_fire), 32'd6);

        // Write then read of the same address on consecutive cycles.
        w = $urandom;
        issue(4'd5, w, 4'hF);
        issue(4'd5, 32'd0, 4'h0);
        drain();
        chk("b2b_new_data", last_rdata, w);

        // Sixteen back-to-back reads give sixteen back-to-back responses.
        n_fire = 0; first_fire = -1; last_fire = -1;
        for (int k = 0; k < WORDS; k++) issue(ADDR_W'(k), 32'd0, 4'h0);
        drain();
        chk("tput_count", 32'(n_fire), 32'd16);
        chk("tput_span", 32'(last_fire - first_fire), 32'd15);

        // Randomised mixed traffic with random response backpressure.
        repeat (400) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = ADDR_W'($urandom_range(0, WORDS - 1));
            req_wdata = $urandom;
            req_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = 1'b0;
        drain();

        // Reset with two reads in flight: nothing may surface afterwards.
        issue(4'd1, 32'd0, 4'h0);
        issue(4'd2, 32'd0, 4'h0);
        do_reset();
        wait_sweep();
        repeat (3) begin
            chk("post_rst_valid", 32'(rsp_valid), 32'd0);
            tick();
        end
        issue(4'd1, 32'd0, 4'h0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
